ip_msxbus_initiator: RTL and testbench

- Host-side MSX-50BUS cycle generator; the bus-master counterpart of the cartridge responders (SCC/ROM/RAM wrappers).
- Turns a single-beat request/response stream into timed slot-select, read-strobe and write-strobe cycles.
- Samples the shared read-data bus, honours the WAIT line, and aborts on a WAIT timeout.
- Used in benches and in host-emulation builds to drive cartridge IP.

---
 rtl/ip_msxbus_initiator.sv | 156 +++++++++++++++
 tb/tb_ip_msxbus_initiator.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ip_msxbus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : ip_msxbus_initiator
//  Description : Host-side MSX-50BUS cycle generator. Converts a single-beat
//                request/response stream into slot-select, read-strobe and
//                write-strobe bus cycles, samples read data, honours n_wait
//                and aborts a cycle on a WAIT timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_msxbus_initiator #(
  parameter int unsigned SETUP_CYC  = 1,    // n_tsltsl-low cycles before strobe
  parameter int unsigned STROBE_CYC = 2,    // minimum strobe-low cycles
  parameter int unsigned HOLD_CYC   = 1,    // idle cycles after release
  parameter int unsigned WAIT_LIMIT = 1024  // 0 disables the WAIT timeout
) (
  input  logic        clk,
  input  logic        n_reset,
  // request / response stream
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  // bus side
  output logic        n_tsltsl,
  output logic        n_trd,
  output logic        n_twr,
  output logic [15:0] ta,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        rdata_en,
  input  logic        n_wait
);

  // Phase counters count from zero, so each phase ends at its length minus one.
  localparam logic [7:0]  SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0]  STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_CYC - 1);
  localparam logic [15:0] WAIT_LAST   = 16'(WAIT_LIMIT - 1);
  localparam bit          TIMEOUT_EN  = (WAIT_LIMIT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  phase_cnt;
  logic [15:0] wait_cnt;
  logic        cyc_write;

  // A new request can only be taken while the bus is idle.
  always_comb begin
    req_ready = (state == ST_IDLE);
  end

  // Bus-cycle sequencer: every bus and response output is registered here.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= ST_IDLE;
      phase_cnt <= 8'd0;
      wait_cnt  <= 16'd0;
      cyc_write <= 1'b0;
      n_tsltsl  <= 1'b1;
      n_trd     <= 1'b1;
      n_twr     <= 1'b1;
      ta        <= 16'h0000;
      wdata     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'hFF;
      rsp_error <= 1'b0;
    end else begin
      // Completion pulse lasts exactly one cycle.
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cyc_write <= req_write;
            ta        <= req_address;
            if (req_write) begin
              wdata <= req_wdata;
            end
            n_tsltsl  <= 1'b0;
            phase_cnt <= 8'd0;
            state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (phase_cnt == SETUP_LAST) begin
            phase_cnt <= 8'd0;
            wait_cnt  <= 16'd0;
            if (cyc_write) begin
              n_twr <= 1'b0;
            end else begin
              n_trd <= 1'b0;
            end
            state <= ST_STROBE;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        ST_STROBE: begin
          if (n_wait) begin
            // Strobe time only advances while the responder is not stalling.
            wait_cnt <= 16'd0;
            if (phase_cnt == STROBE_LAST) begin
              rsp_rdata <= (!cyc_write && rdata_en) ? rdata : 8'hFF;
              rsp_error <= 1'b0;
              rsp_valid <= 1'b1;
              n_trd     <= 1'b1;
              n_twr     <= 1'b1;
              n_tsltsl  <= 1'b1;
              phase_cnt <= 8'd0;
              state     <= ST_HOLD;
            end else begin
              phase_cnt <= phase_cnt + 8'd1;
            end
          end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
            // Responder held WAIT too long: abandon the cycle with an error.
            rsp_rdata <= 8'hFF;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            n_trd     <= 1'b1;
            n_twr     <= 1'b1;
            n_tsltsl  <= 1'b1;
            phase_cnt <= 8'd0;
            state     <= ST_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        ST_HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            state <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ip_msxbus_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ip_msxbus_initiator
//  Description : Directed self-checking bench for ip_msxbus_initiator with a
//                response scoreboard and per-transaction bus-timing checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_msxbus_initiator;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_address;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic        n_tsltsl;
  logic        n_trd;
  logic        n_twr;
  logic [15:0] ta;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_en;
  logic        n_wait;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  ip_msxbus_initiator #(
    .SETUP_CYC (1),
    .STROBE_CYC(2),
    .HOLD_CYC  (1),
    .WAIT_LIMIT(8)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_address(req_address),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .n_tsltsl   (n_tsltsl),
    .n_trd      (n_trd),
    .n_twr      (n_twr),
    .ta         (ta),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_en   (rdata_en),
    .n_wait     (n_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
      end
    end
  end

  // One full transaction; wait_lo < 0 means n_wait stuck low in STROBE.
  // k counts falling edges after the accept edge.
  task automatic run_txn(input string tag, input bit wr, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd_d, input bit rd_en,
                         input int wait_lo, input int exp_strobe,
                         input logic [7:0] exp_rdata, input bit exp_err);
    int   k, slt_n, rd_n, wr_n, rsp_n, rsp_k, strb_first, viol, ready_k;
    exp_t e;
    k = 0;
    while (req_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = addr;
    req_wdata   = wd;
    n_wait      = 1'b1;
    rdata_en    = rd_en;
    rdata       = rd_en ? ~rd_d : rd_d;
    @(posedge clk);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    slt_n = 0; rd_n = 0; wr_n = 0; rsp_n = 0; rsp_k = -1;
    strb_first = -1; viol = 0; ready_k = -1;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      k = i;
      // Requests outside IDLE must be ignored.
      req_write   = ~wr;
      req_address = ~addr;
      req_wdata   = ~wd;
      if (n_tsltsl === 1'b0) slt_n++;
      if (n_trd === 1'b0) rd_n++;
      if (n_twr === 1'b0) wr_n++;
      if ((n_trd === 1'b0 || n_twr === 1'b0) && strb_first < 0) strb_first = k;
      if (n_trd === 1'b0 && n_twr === 1'b0) viol++;
      if ((n_trd === 1'b0 || n_twr === 1'b0) && n_tsltsl !== 1'b0) viol++;
      if (ta !== addr) viol++;
      if (wr && wdata !== wd) viol++;
      if (rsp_valid === 1'b1) begin
        rsp_n++;
        rsp_k = k;
      end
      if (req_ready === 1'b1) begin
        ready_k = k;
        break;
      end
      n_wait = !((wait_lo < 0 && k >= 2) || (k >= 2 && k < 2 + wait_lo));
      if (rd_en) rdata = (k == exp_strobe + 1) ? rd_d : ~rd_d;
    end
    req_valid = 1'b0;
    n_wait    = 1'b1;
    chk({tag, "_tsltsl_cycles"}, slt_n, exp_strobe + 1);
    chk({tag, "_trd_cycles"}, rd_n, wr ? 0 : exp_strobe);
    chk({tag, "_twr_cycles"}, wr_n, wr ? exp_strobe : 0);
    chk({tag, "_strobe_start"}, strb_first, 2);
    chk({tag, "_rsp_pulses"}, rsp_n, 1);
    chk({tag, "_rsp_cycle"}, rsp_k, exp_strobe + 2);
    chk({tag, "_ready_cycle"}, ready_k, exp_strobe + 3);
    chk({tag, "_bus_violations"}, viol, 0);
  endtask

  initial begin
    n_reset     = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = 16'h0000;
    req_wdata   = 8'h00;
    rdata       = 8'h00;
    rdata_en    = 1'b0;
    n_wait      = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tsltsl", n_tsltsl, 1);
    chk("rst_trd", n_trd, 1);
    chk("rst_twr", n_twr, 1);
    chk("rst_ta", ta, 16'h0000);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 8'hFF);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_req_ready", req_ready, 1);
    n_reset = 1'b1;
    @(negedge clk);

    // Basic read, write and undriven read
    run_txn("rd", 1'b0, 16'h7FFC, 8'h00, 8'h5A, 1'b1, 0, 2, 8'h5A, 1'b0);
    run_txn("wr", 1'b1, 16'h7FFC, 8'h83, 8'h5A, 1'b1, 0, 2, 8'hFF, 1'b0);
    run_txn("undrv", 1'b0, 16'h4000, 8'h00, 8'h00, 1'b0, 0, 2, 8'hFF, 1'b0);
    // WAIT stretch of 4 cycles from the first STROBE cycle
    run_txn("wait4", 1'b0, 16'h8123, 8'h00, 8'hC3, 1'b1, 4, 6, 8'hC3, 1'b0);
    // Timeout with n_wait stuck low, then back-to-back normal traffic
    run_txn("tmo", 1'b0, 16'h9000, 8'h00, 8'h5A, 1'b1, -1, 8, 8'hFF, 1'b1);
    run_txn("b2b_rd", 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b1, 0, 2, 8'hA5, 1'b0);
    run_txn("b2b_wr", 1'b1, 16'hFFFF, 8'h3C, 8'h00, 1'b0, 0, 2, 8'hFF, 1'b0);

    // Reset in the middle of a STROBE phase
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_address = 16'h5555;
    rdata_en    = 1'b1;
    rdata       = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pre_trd", n_trd, 0);
    #2 n_reset = 1'b0;
    #1;
    chk("midrst_tsltsl", n_tsltsl, 1);
    chk("midrst_trd", n_trd, 1);
    chk("midrst_twr", n_twr, 1);
    chk("midrst_ta", ta, 16'h0000);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_rsp_rdata", rsp_rdata, 8'hFF);
    repeat (4) @(negedge clk);

    run_txn("post_rst", 1'b0, 16'h2468, 8'h00, 8'h99, 1'b1, 0, 2, 8'h99, 1'b0);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
